l1d_port_arbiter: RTL
=====================

// Module: l1d_port_arbiter
// PURPOSE
//  Shares the single L1-D cache port between two sources: loads from the Load/Store stage, and
//  retired-store drains from the store-buffer head. Loads that hit in the store buffer's
//  forwarding search complete without using the cache. On each store drain it issues the
//  store-buffer pop. Loads win by default; stores win when the buffer is near full or starved.
// PARAMETERS
//  STARVE_LIMIT  8  cycles a valid SB head may wait before stores take priority over loads
//  CNT_W         4  starvation counter width; must hold STARVE_LIMIT
// PORTS
//  CLK            in   1   clock, rising edge
//  RST_N          in   1   asynchronous, active-low reset
//  flush          in   1   speculative flush (same cycle as SB clear_speculative)
//  ld_req         in   1   load request from LS stage
//  ld_addr        in   16  load address
//  ld_ready       out  1   load accepted this cycle (combinational)
//  ld_valid       out  1   load result valid (registered, 1-cycle pulse)
//  ld_data        out  16  load result data
//  sb_search_addr out  16  address driven to SB forwarding search (= ld_addr)
//  sb_match       in   1   SB forwarding hit for sb_search_addr
//  sb_match_data  in   16  forwarded data
//  sb_head_valid  in   1   SB head is valid, executed and retired
//  sb_head_addr   in   16  SB head address
//  sb_head_data   in   16  SB head data
//  sb_stall       in   1   SB near full
//  sb_pop_head    out  1   pop SB head (combinational, 1 cycle)
//  dc_req         out  1   cache request (registered)
//  dc_we          out  1   1 = write, 0 = read
//  dc_addr        out  16  cache address
//  dc_wdata       out  16  cache write data
//  dc_ack         in   1   cache completes the current request this cycle
//  dc_rdata       in   16  read data, valid with dc_ack
// BEHAVIOUR
//  Reset (RST_N=0): state=IDLE, starve_cnt=0, drop=0. Outputs dc_req, dc_we, dc_addr, dc_wdata,
//   ld_valid, ld_data all 0. sb_pop_head=0 and ld_ready=0 while in reset.
//  store_urgent = sb_head_valid & (sb_stall | starve_cnt >= STARVE_LIMIT).
//  IDLE (evaluated in priority order):
//   - flush: ld_ready=0, stay IDLE, clear any pending ld_valid.
//   - ld_req & !store_urgent: ld_ready=1.
//     - sb_match: ld_valid=1, ld_data=sb_match_data on the next cycle; stay IDLE.
//     - else: dc_addr<=ld_addr, dc_we<=0, dc_req<=1; go to LOAD.
//   - else if sb_head_valid: ld_ready=0; dc_addr<=sb_head_addr, dc_wdata<=sb_head_data,
//     dc_we<=1, dc_req<=1, starve_cnt<=0; go to STORE.
//  LOAD: hold dc_req, dc_addr and dc_we. On dc_ack: dc_req<=0, go to IDLE.
//   - If drop=0: ld_valid<=1, ld_data<=dc_rdata.
//   - flush while in LOAD sets drop=1. The request cannot be cancelled, so the block still
//     waits for dc_ack, then suppresses ld_valid and clears drop.
//  STORE: hold the request. sb_pop_head = dc_ack, in the same cycle. On dc_ack: dc_req<=0,
//   go to IDLE. flush is ignored here because retired stores are non-speculative.
//  dc_ack outside LOAD/STORE is ignored. ld_ready=0 in LOAD and STORE.
//  ld_valid and sb_pop_head are single-cycle pulses.
//  starve_cnt: increments when sb_head_valid & state!=STORE; saturates at STARVE_LIMIT;
//   cleared on entry to STORE and whenever sb_head_valid=0.
//  Latency:
//   - forwarded load: ld_valid 1 cycle after acceptance.
//   - cache load: dc_req 1 cycle after acceptance; ld_valid 1 cycle after dc_ack.
//   - every cache access is followed by one IDLE cycle before the next grant.
//  Async reset mid-LOAD/STORE: abandon the access immediately.
//   - No pop and no ld_valid are issued for it.
//   - The SB head stays valid and is re-drained after reset release.
// TESTING
//  1 Forward hit: ld_req addr 0x0040, sb_match=1, sb_match_data=0xBEEF -> ld_ready=1 that cycle;
//    next cycle ld_valid=1, ld_data=0xBEEF; dc_req stays 0.
//  2 Cache load: ld_req 0x0100, sb_match=0, dc_ack 3 cycles after dc_req rises with
//    dc_rdata=0x1234 -> dc_req=1, dc_we=0, dc_addr=0x0100 held; ld_valid=1 with 0x1234 one
//    cycle after ack.
//  3 Store drain: sb_head_valid, addr 0x0200, data 0xA5A5, no loads -> dc_we=1, dc_wdata=0xA5A5;
//    sb_pop_head=1 for exactly the dc_ack cycle.
//  4 Starvation: ld_req held with sb_match=1 and sb_head_valid=1 -> loads are accepted for
//    8 cycles; on the 9th, ld_ready=0 and the store is granted.
//  5 Urgent and flush: sb_stall=1 with ld_req and head valid in the same cycle -> store wins.
//    flush 1 cycle into a LOAD, ack 2 cycles later -> no ld_valid; IDLE next.
//  6 Reset mid-STORE: RST_N=0 while dc_req=1 -> all outputs 0 at once; no sb_pop_head.
//    After release, the head is re-drained.

Source files
------------

// File: rtl/l1d_port_arbiter.sv
// l1d_port_arbiter
//   Shares the single L1-D cache port between loads from the Load/Store stage and
//   retired-store drains from the store-buffer head.
//   - Loads that hit the store-buffer forwarding search complete without a cache access.
//   - Loads win by default.
//   - The store wins when the store buffer is near full, or when its head has waited
//     STARVE_LIMIT cycles.
//
// Ports
//   CLK, RST_N                    clock (rising edge), asynchronous active-low reset
//   flush                         speculative flush; drops an in-flight or new load
//   ld_req, ld_addr               load request from the LS stage
//   ld_ready                      load accepted this cycle (combinational)
//   ld_valid, ld_data             load result (registered 1-cycle pulse)
//   sb_search_addr                address for the SB forwarding search (= ld_addr)
//   sb_match, sb_match_data       SB forwarding hit and its data
//   sb_head_valid/addr/data       retired store at the SB head
//   sb_stall                      SB near full
//   sb_pop_head                   pop the SB head (combinational, on store completion)
//   dc_req/we/addr/wdata          registered cache request
//   dc_ack, dc_rdata              cache completion and read data

module l1d_port_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        flush,
    input  logic        ld_req,
    input  logic [15:0] ld_addr,
    output logic        ld_ready,
    output logic        ld_valid,
    output logic [15:0] ld_data,
    output logic [15:0] sb_search_addr,
    input  logic        sb_match,
    input  logic [15:0] sb_match_data,
    input  logic        sb_head_valid,
    input  logic [15:0] sb_head_addr,
    input  logic [15:0] sb_head_data,
    input  logic        sb_stall,
    output logic        sb_pop_head,
    output logic        dc_req,
    output logic        dc_we,
    output logic [15:0] dc_addr,
    output logic [15:0] dc_wdata,
    input  logic        dc_ack,
    input  logic [15:0] dc_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [1:0]       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             drop;

    logic             store_urgent;
    logic             load_grant;
    logic             store_grant;
    logic             in_idle;

    assign sb_search_addr = ld_addr;

    assign in_idle      = (state == ST_IDLE);
    assign store_urgent = sb_head_valid & (sb_stall | (starve_cnt >= STARVE_MAX));

    // RST_N gating keeps the combinational handshakes quiet while reset is held,
    // even though ld_req may already be asserted by upstream logic.
    assign load_grant  = RST_N & in_idle & ~flush & ld_req & ~store_urgent;
    assign store_grant = in_idle & ~flush & ~(ld_req & ~store_urgent) & sb_head_valid;

    assign ld_ready    = load_grant;
    assign sb_pop_head = RST_N & (state == ST_STORE) & dc_ack;

    // Stage boundary: grant decision -> registered cache request / load result
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            drop       <= 1'b0;
            dc_req     <= 1'b0;
            dc_we      <= 1'b0;
            dc_addr    <= '0;
            dc_wdata   <= '0;
            ld_valid   <= 1'b0;
            ld_data    <= '0;
        end else begin
            ld_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (load_grant) begin
                        if (sb_match) begin
                            ld_valid <= 1'b1;
                            ld_data  <= sb_match_data;
                        end else begin
                            dc_addr <= ld_addr;
                            dc_we   <= 1'b0;
                            dc_req  <= 1'b1;
                            state   <= ST_LOAD;
                        end
                    end else if (store_grant) begin
                        dc_addr  <= sb_head_addr;
                        dc_wdata <= sb_head_data;
                        dc_we    <= 1'b1;
                        dc_req   <= 1'b1;
                        state    <= ST_STORE;
                    end
                end

                ST_LOAD: begin
                    // The cache access cannot be recalled, so a flush only marks the
                    // result for discard; a flush coinciding with the ack also discards.
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    if (dc_ack) begin
                        dc_req <= 1'b0;
                        state  <= ST_IDLE;
                        drop   <= 1'b0;
                        if (!drop && !flush) begin
                            ld_valid <= 1'b1;
                            ld_data  <= dc_rdata;
                        end
                    end
                end

                ST_STORE: begin
                    // Retired stores are non-speculative: flush has no effect here.
                    if (dc_ack) begin
                        dc_req <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end

                default: begin
                    dc_req <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase

            // Head wait time: held while the head is being written, restarted when
            // the head is granted or absent.
            if (!sb_head_valid || store_grant) begin
                starve_cnt <= '0;
            end else if (state != ST_STORE && starve_cnt < STARVE_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule
